cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 11 +
 rtl/cdb_arbiter_rr_pick_n.sv | 48 ++++
 rtl/cdb_arbiter.sv | 51 +++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB packet type and machine-wide CDB/ROB sizing.
package cdb_arbiter_pkg;
    localparam int ROB_SIZE_CLOG = 5;
    localparam int DATA_W = 32;
    localparam int CDB_NUM_LANES = 2;
    typedef struct packed {
        logic                     v;
        logic [ROB_SIZE_CLOG-1:0] robid;
        logic [DATA_W-1:0]        data;
    } cdb_t;
endpackage

// File: rtl/cdb_arbiter_rr_pick_n.sv
// rr_pick_n: round-robin pick of up to LANES requesters starting at ptr_i.
module rr_pick_n #(
    parameter int N = 4,
    parameter int LANES = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IW-1:0]    lane_idx_o [LANES],
    output logic [LANES-1:0] lane_val_o,
    output logic [IW-1:0]    last_idx_o
);
    localparam int CW = $clog2(N + 1);
    logic [2*N-1:0] rot2, unrot2;
    logic [N-1:0]   rot, sel;
    logic [CW-1:0]  cnt;
    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return IW'(s >= N ? s - N : s);
    endfunction
    // Rotate so ptr_i is bit 0, take the first LANES set bits, then rotate back.
    always_comb begin
        rot2 = {req_i, req_i} >> ptr_i;
        rot = rot2[N-1:0];
        sel = '0;
        cnt = '0;
        lane_val_o = '0;
        last_idx_o = ptr_i;
        for (int l = 0; l < LANES; l++) lane_idx_o[l] = '0;
        for (int k = 0; k < N; k++) begin
            if (rot[k] && int'(cnt) < LANES) begin
                sel[k] = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    if (int'(cnt) == l) begin
                        lane_idx_o[l] = wrap(ptr_i, k);
                        lane_val_o[l] = 1'b1;
                    end
                end
                last_idx_o = wrap(ptr_i, k);
                cnt = cnt + CW'(1);
            end
        end
        unrot2 = {sel, sel} << ptr_i;
        gnt_o = unrot2[2*N-1:N];
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of FU results onto registered CDB lanes.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CDB_NUM_LANES = cdb_arbiter_pkg::CDB_NUM_LANES,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_val,
    input  cdb_t               req_pkt [NUM_REQ],
    output logic [NUM_REQ-1:0] req_rdy,
    input  logic               flush,
    output cdb_t               cdb_out [CDB_NUM_LANES],
    output logic [PW-1:0]      rr_ptr
);
    logic [NUM_REQ-1:0]       req_en;
    logic [PW-1:0]            lane_idx [CDB_NUM_LANES];
    logic [CDB_NUM_LANES-1:0] lane_val;
    logic [PW-1:0]            last_idx, rr_ptr_d, rr_ptr_q;
    cdb_t                     cdb_d [CDB_NUM_LANES];
    cdb_t                     cdb_q [CDB_NUM_LANES];
    // Masking at the picker input keeps grants and lane valids consistent under rst/flush.
    assign req_en = (rst || flush) ? '0 : req_val;
    rr_pick_n #(.N(NUM_REQ), .LANES(CDB_NUM_LANES)) u_pick (
        .req_i      (req_en),
        .ptr_i      (rr_ptr_q),
        .gnt_o      (req_rdy),
        .lane_idx_o (lane_idx),
        .lane_val_o (lane_val),
        .last_idx_o (last_idx)
    );
    always_comb begin
        rr_ptr_d = flush ? '0 : !(|req_rdy) ? rr_ptr_q :
                   (int'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + PW'(1);
        for (int l = 0; l < CDB_NUM_LANES; l++)
            cdb_d[l] = '{v: lane_val[l], robid: req_pkt[lane_idx[l]].robid, data: req_pkt[lane_idx[l]].data};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int l = 0; l < CDB_NUM_LANES; l++) cdb_q[l] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q <= cdb_d;
        end
    end
    assign cdb_out = cdb_q;
    assign rr_ptr = rr_ptr_q;
endmodule
